uart_echo_fifo: RTL and testbench

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

---
 rtl/uart_echo_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_echo_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// Receive-to-transmit echo buffer: queues bytes from uart_rx and replays them to
// uart_tx one frame at a time, with a sticky overflow flag and a last-byte display register.
module uart_echo_fifo #(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      echo_en,
  input  logic [PAYLOAD_BITS-1:0]   rx_data,
  input  logic                      rx_valid,
  input  logic                      rx_break,
  input  logic                      tx_busy,
  output logic [PAYLOAD_BITS-1:0]   tx_data,
  output logic                      tx_en,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  output logic [PAYLOAD_BITS-1:0]   last_rx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [1:0]  QUIET_LAST = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  tx_state_t state_q;
  tx_state_t state_d;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [1:0]              quiet_cnt;

  logic empty_c;
  logic full_c;
  logic rx_good_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  assign empty_c   = (fifo_count == '0);
  assign full_c    = (fifo_count == CW'(DEPTH));
  assign rx_good_c = rx_valid & ~rx_break;

  // Transmit sequencer: pop one byte, strobe once, then track the frame via tx_busy.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_c && echo_en && !tx_busy) begin
          state_d = LAUNCH;
          pop_c   = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (quiet_cnt == QUIET_LAST) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push_c = rx_good_c & (~full_c | pop_c);
  assign drop_c = rx_good_c & full_c & ~pop_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counts idle cycles in WAIT_BUSY so a transmitter that never reports busy cannot stall us.
  always_ff @(posedge clk) begin
    if (reset || (state_q != WAIT_BUSY)) begin
      quiet_cnt <= 2'd0;
    end else begin
      quiet_cnt <= quiet_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= fifo_count + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      last_rx  <= '0;
    end else begin
      if (drop_c) begin
        overflow <= 1'b1;
      end
      if (push_c) begin
        last_rx <= rx_data;
      end
    end
  end

  // tx_en is high exactly for the LAUNCH cycle; tx_data holds until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_en <= pop_c;
      if (pop_c) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: queue-based reference model checked every cycle,
// plus literal expectations for the echo, overflow, break, full-pop, timeout and reset scenarios.
module tb_uart_echo_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       reset;
  logic       echo_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_break;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_en;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [7:0] last_rx;

  uart_echo_fifo #(.PAYLOAD_BITS(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .echo_en    (echo_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_break   (rx_break),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .last_rx    (last_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_len = 10;
  bit chk_on = 1'b0;
  logic [7:0] emitted[$];
  int         emit_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the FIFO is a queue, the transmitter a phase number.
  logic [7:0] q[$];
  int         m_phase = 0;
  int         m_quiet = 0;
  logic       m_txen  = 1'b0;
  logic       m_ovf   = 1'b0;
  logic [7:0] m_txdata = 8'h00;
  logic [7:0] m_last   = 8'h00;

  always @(posedge clk) begin : mdl
    bit pop;
    bit acc;
    bit full;
    if (reset) begin
      q.delete();
      m_phase  = 0;
      m_quiet  = 0;
      m_txen   = 1'b0;
      m_ovf    = 1'b0;
      m_txdata = 8'h00;
      m_last   = 8'h00;
    end else begin
      full = (q.size() == DEPTH);
      pop  = (m_phase == 0) && (q.size() != 0) && echo_en && !tx_busy;
      acc  = rx_valid && !rx_break && (!full || pop);
      if (rx_valid && !rx_break && !acc) m_ovf = 1'b1;
      m_txen = pop;
      case (m_phase)
        0: if (pop) m_phase = 1;
        1: begin m_phase = 2; m_quiet = 0; end
        2: begin
          if (tx_busy) m_phase = 3;
          else begin
            m_quiet++;
            if (m_quiet == 3) m_phase = 0;
          end
        end
        default: if (!tx_busy) m_phase = 0;
      endcase
      if (pop) m_txdata = q.pop_front();
      if (acc) begin
        q.push_back(rx_data);
        m_last = rx_data;
      end
    end
  end

  // Per-cycle compare against the model, and a record of every launched byte.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("tx_en", int'(tx_en), int'(m_txen));
      chk("tx_data", int'(tx_data), int'(m_txdata));
      chk("fifo_count", int'(fifo_count), q.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("last_rx", int'(last_rx), int'(m_last));
      if (tx_en && tx_busy) chk("tx_en_while_busy", 1, 0);
      if (tx_en) begin
        emitted.push_back(tx_data);
        emit_cyc.push_back(cyc);
      end
    end
  end

  // Transmitter stand-in: goes busy the cycle after a launch for busy_len cycles (0 = never busy).
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en && busy_len > 0) begin
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_break = 1'b0;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; echo_en = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_break = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_tx_en", int'(tx_en), 0);
    chk("reset_overflow", int'(overflow), 0);

    // Single echo with two-cycle latency.
    echo_en = 1'b1; busy_len = 10;
    push(8'h41);
    chk("echo_count_after_push", int'(fifo_count), 1);
    chk("echo_tx_en_early", int'(tx_en), 0);
    @(negedge clk);
    chk("echo_tx_en", int'(tx_en), 1);
    chk("echo_tx_data", int'(tx_data), 8'h41);
    repeat (14) @(negedge clk);
    chk("echo_count_final", int'(fifo_count), 0);
    chk("echo_pulses", emitted.size(), 1);

    // Fill past capacity with echo disabled, then drain in order.
    echo_en = 1'b0;
    emitted.delete();
    for (int i = 0; i <= 16; i++) push(8'(i));
    chk("fill_count", int'(fifo_count), 16);
    chk("fill_overflow", int'(overflow), 1);
    chk("fill_last_rx", int'(last_rx), 8'h0F);
    echo_en = 1'b1;
    repeat (260) @(negedge clk);
    chk("drain_pulses", emitted.size(), 16);
    for (int i = 0; i < 16 && i < emitted.size(); i++) chk("drain_order", int'(emitted[i]), i);
    chk("drain_overflow_sticky", int'(overflow), 1);

    // Break cycles are ignored entirely.
    echo_en = 1'b0;
    emitted.delete();
    push(8'h33);
    rx_valid = 1'b1; rx_break = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0; rx_break = 1'b0;
    chk("break_count", int'(fifo_count), 1);
    chk("break_last_rx", int'(last_rx), 8'h33);
    repeat (5) @(negedge clk);
    chk("break_no_tx", emitted.size(), 0);

    // Push into a full FIFO on the same edge as a pop.
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    chk("full_count", int'(fifo_count), 16);
    chk("full_overflow", int'(overflow), 0);
    emitted.delete();
    echo_en = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    @(negedge clk);
    rx_valid = 1'b0; echo_en = 1'b0;
    chk("fullpop_count", int'(fifo_count), 16);
    chk("fullpop_overflow", int'(overflow), 0);
    chk("fullpop_last_rx", int'(last_rx), 8'hAA);
    chk("fullpop_tx_data", int'(tx_data), 8'h80);
    echo_en = 1'b1;
    repeat (240) @(negedge clk);
    chk("fullpop_pulses", emitted.size(), 17);
    if (emitted.size() == 17) begin
      chk("fullpop_second", int'(emitted[1]), 8'h81);
      chk("fullpop_tail", int'(emitted[16]), 8'hAA);
    end

    // Transmitter never reports busy: timeout, then exactly one launch per byte.
    do_reset();
    busy_len = 0; echo_en = 1'b1;
    emitted.delete(); emit_cyc.delete();
    push(8'h11);
    push(8'h22);
    repeat (20) @(negedge clk);
    chk("timeout_pulses", emitted.size(), 2);
    if (emitted.size() == 2) begin
      chk("timeout_gap", emit_cyc[1] - emit_cyc[0], 5);
      chk("timeout_first", int'(emitted[0]), 8'h11);
      chk("timeout_second", int'(emitted[1]), 8'h22);
    end

    // Reset in the middle of a frame with bytes queued.
    busy_len = 10;
    emitted.delete();
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
    repeat (2) @(negedge clk);
    chk("midreset_queued", int'(fifo_count), 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_count", int'(fifo_count), 0);
    chk("midreset_tx_en", int'(tx_en), 0);
    chk("midreset_tx_data", int'(tx_data), 0);
    chk("midreset_last_rx", int'(last_rx), 0);
    chk("midreset_overflow", int'(overflow), 0);
    repeat (25) @(negedge clk);
    chk("midreset_no_more_tx", emitted.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
